cpu_control_sequencer: RTL

Multi-cycle control FSM for the three-bus CPU datapath: it fetches each instruction from memory into the instruction register over bus C, reads back the latched instruction, decodes the opcode and drives the register-file, ALU and bus enables for execute and writeback. All datapath blocks (PC, MAR/MDR, instruction register, register file, ALU) receive their enables only from this block.

---
 rtl/cpu_control_sequencer_if.sv | 41 ++++
 rtl/cpu_control_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cpu_control_sequencer_if.sv
// Control/status bundle between the CPU control sequencer and the datapath it drives.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface cpu_control_sequencer_if;
  logic        start;
  logic [31:0] INSTRN_DATA_IN;
  logic        mem_ready;

  logic        pc_out;
  logic        mar_in;
  logic        mem_rd;
  logic        mdr_out;
  logic        busc_in;
  logic        pc_inc;
  logic        instrn_out;

  logic [4:0]  rega_sel;
  logic [4:0]  regb_sel;
  logic [4:0]  regc_sel;
  logic        reg_a_out;
  logic        reg_b_out;
  logic        reg_c_in;
  logic [3:0]  alu_op;

  logic        halted;
  logic        fault;
  logic [15:0] instr_count;

  modport master (
    input  start, INSTRN_DATA_IN, mem_ready,
    output pc_out, mar_in, mem_rd, mdr_out, busc_in, pc_inc, instrn_out,
    output rega_sel, regb_sel, regc_sel, reg_a_out, reg_b_out, reg_c_in, alu_op,
    output halted, fault, instr_count
  );

  modport slave (
    output start, INSTRN_DATA_IN, mem_ready,
    input  pc_out, mar_in, mem_rd, mdr_out, busc_in, pc_inc, instrn_out,
    input  rega_sel, regb_sel, regc_sel, reg_a_out, reg_b_out, reg_c_in, alu_op,
    input  halted, fault, instr_count
  );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control FSM for the three-bus CPU datapath.
// Enables are registered from the next state; register selects decode state plus latched fields.
module cpu_control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                      clk,
  input logic                      rst,
  cpu_control_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH0, FETCH_WAIT, FETCH1, DECODE, EXEC, WB, HALT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state, state_n;
  logic [7:0]  wait_cnt;
  logic [5:0]  opcode_q;
  logic [4:0]  rd_q, rs_q, rt_q;
  logic [15:0] count_q;
  logic        fault_q;
  logic        pc_out_q, mar_in_q, mem_rd_q, mdr_out_q, busc_in_q, pc_inc_q, instrn_out_q;
  logic        reg_a_out_q, reg_b_out_q, reg_c_in_q, halted_q;

  logic [5:0]  opcode_in;
  logic        is_alu;
  logic        timeout;
  logic        retire;
  logic        unused_bits;

  assign opcode_in   = bus.INSTRN_DATA_IN[31:26];
  assign is_alu      = (opcode_in[5:4] == 2'b00) && (opcode_in != 6'h00);
  assign timeout     = (wait_cnt == WAIT_LAST);
  assign retire      = ((state == DECODE) && (opcode_in == 6'h00)) || (state == WB);
  assign unused_bits = &{1'b0, opcode_q[5:4], bus.INSTRN_DATA_IN[10:0]};

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       if (bus.start) state_n = FETCH0;
      FETCH0:     state_n = FETCH_WAIT;
      // ready takes priority over the final timeout cycle
      FETCH_WAIT: if (bus.mem_ready) state_n = FETCH1;
                  else if (timeout)  state_n = HALT;
      FETCH1:     state_n = DECODE;
      DECODE:     if (opcode_in == 6'h00) state_n = FETCH0;
                  else if (is_alu)        state_n = EXEC;
                  else                    state_n = HALT;
      EXEC:       state_n = WB;
      WB:         state_n = FETCH0;
      HALT:       if (bus.start) state_n = FETCH0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      opcode_q     <= '0;
      rd_q         <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      count_q      <= '0;
      fault_q      <= 1'b0;
      pc_out_q     <= 1'b0;
      mar_in_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mdr_out_q    <= 1'b0;
      busc_in_q    <= 1'b0;
      pc_inc_q     <= 1'b0;
      instrn_out_q <= 1'b0;
      reg_a_out_q  <= 1'b0;
      reg_b_out_q  <= 1'b0;
      reg_c_in_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state        <= state_n;
      pc_out_q     <= (state_n == FETCH0);
      mar_in_q     <= (state_n == FETCH0);
      mem_rd_q     <= (state_n == FETCH0) || (state_n == FETCH_WAIT);
      mdr_out_q    <= (state_n == FETCH1);
      busc_in_q    <= (state_n == FETCH1);
      pc_inc_q     <= (state_n == FETCH1);
      instrn_out_q <= (state_n == DECODE);
      reg_a_out_q  <= (state_n == EXEC);
      reg_b_out_q  <= (state_n == EXEC);
      reg_c_in_q   <= (state_n == WB);
      halted_q     <= (state_n == HALT);

      if (state == FETCH0)
        wait_cnt <= '0;
      else if ((state == FETCH_WAIT) && !bus.mem_ready)
        wait_cnt <= wait_cnt + 8'd1;

      if (state == DECODE)
        {opcode_q, rd_q, rs_q, rt_q} <= bus.INSTRN_DATA_IN[31:11];

      if (retire)
        count_q <= count_q + 16'd1;

      if ((state == FETCH_WAIT) && !bus.mem_ready && timeout)
        fault_q <= 1'b1;
      else if ((state == DECODE) && (state_n == HALT) && (opcode_in != 6'h3F))
        fault_q <= 1'b1;
      else if ((state == HALT) && bus.start)
        fault_q <= 1'b0;
    end
  end

  assign bus.pc_out      = pc_out_q;
  assign bus.mar_in      = mar_in_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mdr_out     = mdr_out_q;
  assign bus.busc_in     = busc_in_q;
  assign bus.pc_inc      = pc_inc_q;
  assign bus.instrn_out  = instrn_out_q;
  assign bus.reg_a_out   = reg_a_out_q;
  assign bus.reg_b_out   = reg_b_out_q;
  assign bus.reg_c_in    = reg_c_in_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.instr_count = count_q;

  assign bus.rega_sel = (state == EXEC) ? rs_q : '0;
  assign bus.regb_sel = (state == EXEC) ? rt_q : '0;
  assign bus.regc_sel = (state == WB)   ? rd_q : '0;
  assign bus.alu_op   = ((state == EXEC) || (state == WB)) ? opcode_q[3:0] : '0;

endmodule
